// File: rtl/if_id_issue_ctrl.sv
// Presents the two instructions of an IF/ID fetch pair to a single-issue decode stage, one per cycle.
// It also drives the IF/ID stall and flush inputs and keeps the issue and backpressure counters.
module if_id_issue_ctrl #(
    parameter int PC_STEP = 4,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_inst_en,
    input  logic             id_inst2_vld,
    input  logic [31:0]      id_pc,
    input  logic [31:0]      id_inst1,
    input  logic [31:0]      id_inst2,
    input  logic             redirect,
    input  logic             dec_ready,
    input  logic             cnt_clr,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             dec_valid,
    output logic [31:0]      dec_inst,
    output logic [31:0]      dec_pc,
    output logic             dec_slot,
    output logic [CNT_W-1:0] issue_cnt,
    output logic [CNT_W-1:0] bp_cnt
);

    typedef enum logic {
        S0 = 1'b0,
        S1 = 1'b1
    } state_e;

    localparam logic [31:0] PC_STEP_W = 32'(PC_STEP);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0] bp_cnt_q, bp_cnt_d;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
        state_d    = state_q;
        dec_valid  = 1'b0;
        ifid_stall = 1'b0;
        dec_slot   = 1'b0;
        dec_inst   = id_inst1;
        dec_pc     = id_pc;

        unique case (state_q)
            S0: begin
                dec_valid  = id_inst_en;
                ifid_stall = id_inst_en & (~dec_ready | id_inst2_vld);
                state_d    = (id_inst_en & dec_ready & id_inst2_vld) ? S1 : S0;
            end
            S1: begin
                dec_inst   = id_inst2;
                dec_pc     = id_pc + PC_STEP_W;
                dec_slot   = 1'b1;
                dec_valid  = id_inst_en;
                ifid_stall = id_inst_en & ~dec_ready;
                state_d    = (dec_ready | ~id_inst_en) ? S0 : S1;
            end
            default: state_d = S0;
        endcase

        // A redirect kills whatever is presented, so nothing can transfer in that cycle.
        if (redirect) begin
            dec_valid  = 1'b0;
            ifid_stall = 1'b0;
            state_d    = S0;
        end

        if (!rst) begin
            dec_valid  = 1'b0;
            ifid_stall = 1'b0;
        end
    end

    assign ifid_flush = redirect & rst;

    always_comb begin
        issue_cnt_d = issue_cnt_q + CNT_W'(dec_valid & dec_ready);
        bp_cnt_d    = bp_cnt_q + CNT_W'(dec_valid & ~dec_ready);
        if (cnt_clr) begin
            issue_cnt_d = '0;
            bp_cnt_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
        if (!rst) begin
            state_q     <= S0;
            issue_cnt_q <= '0;
            bp_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            bp_cnt_q    <= bp_cnt_d;
        end
    end

    assign issue_cnt = issue_cnt_q;
    assign bp_cnt    = bp_cnt_q;

endmodule
